// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, MIPS opcode/funct
// encodings and the issue FSM state type.
package alu_pkg;

    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: opcode/funct/shamt/imm/rs/rt -> ALU operands,
// op code and writeback/trap/illegal attributes.
module alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [15:0]        imm,
    input  logic [DATA_W-1:0]  rs_val,
    input  logic [DATA_W-1:0]  rt_val,
    output logic [DATA_W-1:0]  a,
    output logic [DATA_W-1:0]  b,
    output logic [3:0]         aluc,
    output logic               wb_en,
    output logic               trap_ovf,
    output logic               illegal
);

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt_ext;
    logic              legal;

    assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext  = {{(DATA_W-16){1'b0}}, imm};
    assign shamt_ext = {{(DATA_W-SHAMT_W){1'b0}}, shamt};

    always_comb begin
        legal    = 1'b1;
        trap_ovf = 1'b0;
        wb_en    = 1'b1;
        a        = rs_val;
        b        = rt_val;
        aluc     = ALUC_ADDU;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  begin aluc = ALUC_ADD; trap_ovf = 1'b1; end
                FN_ADDU: aluc = ALUC_ADDU;
                FN_SUB:  begin aluc = ALUC_SUB; trap_ovf = 1'b1; end
                FN_SUBU: aluc = ALUC_SUBU;
                FN_AND:  aluc = ALUC_AND;
                FN_OR:   aluc = ALUC_OR;
                FN_XOR:  aluc = ALUC_XOR;
                FN_NOR:  aluc = ALUC_NOR;
                FN_SLT:  aluc = ALUC_SLT;
                FN_SLTU: aluc = ALUC_SLTU;
                // Constant shifts carry the amount in operand a
                FN_SLL:  begin aluc = ALUC_SLL; a = shamt_ext; end
                FN_SRL:  begin aluc = ALUC_SRL; a = shamt_ext; end
                FN_SRA:  begin aluc = ALUC_SRA; a = shamt_ext; end
                FN_SLLV: aluc = ALUC_SLL;
                FN_SRLV: aluc = ALUC_SRL;
                FN_SRAV: aluc = ALUC_SRA;
                default: legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI:  begin aluc = ALUC_ADD; b = imm_sext; trap_ovf = 1'b1; end
                OP_ADDIU: begin aluc = ALUC_ADDU; b = imm_sext; end
                OP_SLTI:  begin aluc = ALUC_SLT;  b = imm_sext; end
                OP_SLTIU: begin aluc = ALUC_SLTU; b = imm_sext; end
                OP_ANDI:  begin aluc = ALUC_AND;  b = imm_zext; end
                OP_ORI:   begin aluc = ALUC_OR;   b = imm_zext; end
                OP_XORI:  begin aluc = ALUC_XOR;  b = imm_zext; end
                OP_LUI:   begin aluc = ALUC_LUI;  b = imm_zext; end
                // Branch compares only need the zero flag of rs-rt
                OP_BEQ, OP_BNE: begin aluc = ALUC_SUB; wb_en = 1'b0; end
                default:  legal = 1'b0;
            endcase
        end
        if (!legal) begin
            a        = '0;
            b        = '0;
            aluc     = ALUC_ADDU;
            wb_en    = 1'b0;
            trap_ovf = 1'b0;
        end
        illegal = !legal;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 32-bit ALU: accept, register operands,
// capture result/flags, hold until consumed. Optional overflow trap: TRAP_OVF_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_opcode,
    input  logic [5:0]         in_funct,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [15:0]        in_imm,
    input  logic [DATA_W-1:0]  in_rs_val,
    input  logic [DATA_W-1:0]  in_rt_val,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_aluc,
    input  logic [DATA_W-1:0]  alu_r,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_negative,
    input  logic               alu_overflow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [3:0]         out_flags,
    output logic               out_wb_en,
    output logic               out_exc_ovf,
    output logic               out_illegal
);

`ifdef TRAP_OVF_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t state_reg;
    state_t state_next;
    logic   accept;
    logic   capture;

    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [3:0]        dec_aluc;
    logic              dec_wb_en;
    logic              dec_trap_ovf;
    logic              dec_illegal;

    logic wb_attr_reg;
    logic trap_attr_reg;
    logic illegal_attr_reg;
    logic trap_hit;

    alu_decode #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .opcode   (in_opcode),
        .funct    (in_funct),
        .shamt    (in_shamt),
        .imm      (in_imm),
        .rs_val   (in_rs_val),
        .rt_val   (in_rt_val),
        .a        (dec_a),
        .b        (dec_b),
        .aluc     (dec_aluc),
        .wb_en    (dec_wb_en),
        .trap_ovf (dec_trap_ovf),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

    // Trapping suppresses writeback; the flags themselves are captured unchanged
    assign trap_hit = TRAP_EN & trap_attr_reg & alu_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a            <= '0;
            alu_b            <= '0;
            alu_aluc         <= '0;
            wb_attr_reg      <= 1'b0;
            trap_attr_reg    <= 1'b0;
            illegal_attr_reg <= 1'b0;
            out_result       <= '0;
            out_flags        <= '0;
            out_wb_en        <= 1'b0;
            out_exc_ovf      <= 1'b0;
            out_illegal      <= 1'b0;
        end else begin
            if (accept) begin
                alu_a            <= dec_a;
                alu_b            <= dec_b;
                alu_aluc         <= dec_aluc;
                wb_attr_reg      <= dec_wb_en;
                trap_attr_reg    <= dec_trap_ovf;
                illegal_attr_reg <= dec_illegal;
            end
            if (capture) begin
                out_result  <= alu_r;
                out_flags   <= {alu_zero, alu_carry, alu_negative, alu_overflow};
                out_wb_en   <= wb_attr_reg & ~trap_hit;
                out_exc_ovf <= trap_hit;
                out_illegal <= illegal_attr_reg;
            end
        end
    end

endmodule
